i2c_master_write_ctrl: RTL and testbench

//  Parametrised I2C master for multi-byte writes to a 7-bit-addressed device. Generates START,

---
 rtl/i2c_master_write_ctrl.sv | 166 ++++++++++++++++
 tb/tb_i2c_master_write_ctrl.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_master_write_ctrl.sv
// i2c_master_write_ctrl
//   I2C master for multi-byte writes to a 7-bit-addressed device. It sends
//   START, the address with W=0, a stream of data bytes and then STOP. It
//   samples the slave ACK after every byte. The SCL period is 4*CLK_DIV clk.
// Ports
//   clk, reset          system clock; asynchronous active-low reset
//   start, dev_addr     transfer request (taken only when idle) and address
//   tx_data/last/valid  byte stream in; tx_ready is high only while waiting
//                       for the next byte
//   sda_in              synchronised SDA pad level
//   sda_oe, scl_oe      open-drain pulls (1 = drive low)
//   busy, done, nack    busy from accept to STOP end; done pulses once at
//                       STOP end; nack is sticky until the next accepted start
module i2c_master_write_ctrl #(
  parameter int CLK_DIV      = 250,
  parameter bit STOP_ON_NACK = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [6:0] dev_addr,
  input  logic [7:0] tx_data,
  input  logic       tx_last,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic       scl_oe,
  output logic       busy,
  output logic       done,
  output logic       nack
);

  localparam int QW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [QW-1:0] QLAST = QW'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    IDLE, START, ADDR, ADDR_ACK, LOAD, DATA, DATA_ACK, STOP
  } state_t;

  state_t        state, state_n;
  logic [QW-1:0] qc, qc_n;        // clk count within a quarter
  logic [1:0]    q, q_n;          // quarter index within a bit
  logic [2:0]    bc, bc_n;        // bit index, 7 down to 0
  logic [7:0]    sh, sh_n;        // byte being shifted out
  logic          last, last_n;
  logic          slot_nack, slot_nack_n;  // ACK-slot result of the current byte
  logic          sda_d, scl_d;

  logic q_end, bit_end, sample, accept, ack_state;
  assign q_end     = (qc == QLAST);
  assign bit_end   = q_end && (q == 2'd3);
  assign sample    = q_end && (q == 2'd2);
  assign ack_state = (state == ADDR_ACK) || (state == DATA_ACK);
  // Blocking on done keeps a start in the completion cycle from being taken.
  assign accept    = (state == IDLE) && start && !busy && !done;
  assign tx_ready  = (state == LOAD);

  // State register and registered pin drivers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      qc        <= '0;
      q         <= '0;
      bc        <= '0;
      sh        <= '0;
      last      <= 1'b0;
      slot_nack <= 1'b0;
      sda_oe    <= 1'b0;
      scl_oe    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      nack      <= 1'b0;
    end else begin
      state     <= state_n;
      qc        <= qc_n;
      q         <= q_n;
      bc        <= bc_n;
      sh        <= sh_n;
      last      <= last_n;
      slot_nack <= slot_nack_n;
      sda_oe    <= sda_d;
      scl_oe    <= scl_d;
      busy      <= (state_n != IDLE);
      done      <= (state == STOP) && bit_end;
      if (accept)
        nack <= 1'b0;
      else if (ack_state && sample && sda_in)
        nack <= 1'b1;
    end
  end

  // Next-state logic. The bit timer is frozen in IDLE and LOAD, so every
  // other state is entered with the timer at Q0, count 0.
  always_comb begin
    state_n     = state;
    qc_n        = qc;
    q_n         = q;
    bc_n        = bc;
    sh_n        = sh;
    last_n      = last;
    slot_nack_n = slot_nack;
    if (state != IDLE && state != LOAD) begin
      qc_n = q_end ? '0 : qc + 1'b1;
      if (q_end) q_n = q + 2'd1;
    end
    case (state)
      IDLE: if (accept) begin
        state_n = START;
        sh_n    = {dev_addr, 1'b0};
        qc_n    = '0;
        q_n     = '0;
        bc_n    = 3'd7;
      end
      START: if (bit_end) begin
        state_n = ADDR;
        bc_n    = 3'd7;
      end
      ADDR, DATA: if (bit_end) begin
        if (bc == 3'd0) state_n = (state == ADDR) ? ADDR_ACK : DATA_ACK;
        else            bc_n = bc - 3'd1;
      end
      ADDR_ACK, DATA_ACK: begin
        if (sample) slot_nack_n = sda_in;
        if (bit_end) begin
          if (slot_nack && STOP_ON_NACK)             state_n = STOP;
          else if (state == DATA_ACK && last)        state_n = STOP;
          else                                       state_n = LOAD;
        end
      end
      LOAD: if (tx_valid) begin
        state_n = DATA;
        sh_n    = tx_data;
        last_n  = tx_last;
        bc_n    = 3'd7;
      end
      STOP: if (bit_end) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Pin levels for the cycle being entered. They are derived from the next
  // state, so the registered pins change exactly on quarter boundaries.
  always_comb begin
    sda_d = 1'b0;
    scl_d = 1'b0;
    case (state_n)
      START:              sda_d = q_n[1];
      ADDR, DATA: begin
        scl_d = ~q_n[1];
        sda_d = ~sh_n[bc_n];
      end
      ADDR_ACK, DATA_ACK: scl_d = ~q_n[1];
      LOAD: begin
        scl_d = 1'b1;
        sda_d = sda_oe;
      end
      STOP: begin
        scl_d = ~q_n[1];
        sda_d = (q_n != 2'd3);
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_i2c_master_write_ctrl.sv
// Directed bench: inst 0 aborts on NACK, inst 1 continues past a NACK.
// A bus monitor decodes 9-bit frames ({byte, ack}) and also acts as the slave.
module tb_i2c_master_write_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [1:0] start_v = '0, tx_last_v = '0, tx_valid_v = '0;
  logic [1:0] tx_ready_v, sda_in_v, sda_oe_v, scl_oe_v, busy_v, done_v, nack_v;
  logic [6:0] addr_v [2];
  logic [7:0] data_v [2];
  int total = 0, bad = 0;

  // slave / monitor state
  logic [1:0]  rel = 2'b11, prev_scl = '0, prev_sda = '0;
  logic [15:0] plan [2];           // bit k = 1: slave NACKs frame k
  logic [8:0]  acc [2];
  logic [8:0]  frames [2][64];
  int nfr [2], starts [2], stops [2], done_cnt [2], busy_cyc [2], ready_cnt [2], rises [2];

  assign sda_in_v = ~sda_oe_v & rel;

  i2c_master_write_ctrl #(.CLK_DIV(2), .STOP_ON_NACK(1'b1)) dut (
    .clk(clk), .reset(reset), .start(start_v[0]), .dev_addr(addr_v[0]),
    .tx_data(data_v[0]), .tx_last(tx_last_v[0]), .tx_valid(tx_valid_v[0]),
    .tx_ready(tx_ready_v[0]), .sda_in(sda_in_v[0]), .sda_oe(sda_oe_v[0]),
    .scl_oe(scl_oe_v[0]), .busy(busy_v[0]), .done(done_v[0]), .nack(nack_v[0]));

  i2c_master_write_ctrl #(.CLK_DIV(2), .STOP_ON_NACK(1'b0)) dut_cont (
    .clk(clk), .reset(reset), .start(start_v[1]), .dev_addr(addr_v[1]),
    .tx_data(data_v[1]), .tx_last(tx_last_v[1]), .tx_valid(tx_valid_v[1]),
    .tx_ready(tx_ready_v[1]), .sda_in(sda_in_v[1]), .sda_oe(sda_oe_v[1]),
    .scl_oe(scl_oe_v[1]), .busy(busy_v[1]), .done(done_v[1]), .nack(nack_v[1]));

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (busy_v[i])     busy_cyc[i]++;
      if (done_v[i])     done_cnt[i]++;
      if (tx_ready_v[i]) ready_cnt[i]++;
      if (!prev_scl[i] && !scl_oe_v[i] && !prev_sda[i] && sda_oe_v[i]) begin
        starts[i]++;
        rises[i] = 0;
        rel[i]   = 1'b1;
      end else if (!prev_scl[i] && !scl_oe_v[i] && prev_sda[i] && !sda_oe_v[i])
        stops[i]++;
      if (prev_scl[i] && !scl_oe_v[i]) begin
        acc[i] = {acc[i][7:0], sda_in_v[i]};
        rises[i]++;
        if (rises[i] % 9 == 0 && nfr[i] < 64) begin
          frames[i][nfr[i]] = acc[i];
          nfr[i]++;
        end
      end
      if (!prev_scl[i] && scl_oe_v[i])
        rel[i] = (rises[i] % 9 == 8) ? plan[i][(rises[i] / 9) % 16] : 1'b1;
      prev_scl[i] = scl_oe_v[i];
      prev_sda[i] = sda_oe_v[i];
    end
  end

  task automatic wait_done(input int i, input string nm);
    int g = 0;
    while (done_v[i] !== 1'b1 && g < 3000) begin @(negedge clk); g++; end
    total++;
    if (g >= 3000) begin bad++; $display("FAIL %s: no done pulse within %0d cycles", nm, g); end
  endtask

  // Waits for tx_ready, holds tx_valid low for pre_delay cycles, then hands over one byte.
  task automatic feed(input int i, input logic [7:0] b, input logic lst, input int pre_delay,
                      output int loadlow);
    int g = 0;
    loadlow = 0;
    while (tx_ready_v[i] !== 1'b1 && g < 3000) begin @(negedge clk); g++; end
    total++;
    if (g >= 3000) begin bad++; $display("FAIL feed_ready inst%0d: tx_ready never rose", i); return; end
    repeat (pre_delay) begin
      if (scl_oe_v[i] && tx_ready_v[i]) loadlow++;
      @(negedge clk);
    end
    data_v[i] = b; tx_last_v[i] = lst; tx_valid_v[i] = 1'b1;
    @(negedge clk);
    tx_valid_v[i] = 1'b0; tx_last_v[i] = 1'b0;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      total++;
      if ({sda_oe_v[i], scl_oe_v[i], busy_v[i], done_v[i], nack_v[i], tx_ready_v[i]} !== 6'b0) begin
        bad++;
        $display("FAIL reset_outs inst%0d: got %b want 000000", i,
                 {sda_oe_v[i], scl_oe_v[i], busy_v[i], done_v[i], nack_v[i], tx_ready_v[i]});
      end
    end
    @(negedge clk); reset = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if ({busy_v, sda_oe_v, scl_oe_v} !== 6'b0) begin
      bad++; $display("FAIL idle_after_reset: got %b want 000000", {busy_v, sda_oe_v, scl_oe_v});
    end
  endtask

  task automatic test_single_byte();
    int s_fr = nfr[0], s_st = starts[0], s_sp = stops[0], s_dn = done_cnt[0], s_bz = busy_cyc[0];
    plan[0] = '0;
    addr_v[0] = 7'h50; data_v[0] = 8'hAA; tx_last_v[0] = 1'b1; tx_valid_v[0] = 1'b1;
    start_v[0] = 1'b1;
    @(negedge clk); start_v[0] = 1'b0;
    wait_done(0, "t1_done");
    tx_valid_v[0] = 1'b0; tx_last_v[0] = 1'b0;
    @(negedge clk);
    total++; if (nfr[0] - s_fr != 2) begin bad++; $display("FAIL t1_frames: got %0d want 2", nfr[0] - s_fr); end
    total++; if (frames[0][s_fr] !== 9'h140) begin bad++; $display("FAIL t1_addr: got %h want 140", frames[0][s_fr]); end
    total++; if (frames[0][s_fr+1] !== 9'h154) begin bad++; $display("FAIL t1_data: got %h want 154", frames[0][s_fr+1]); end
    total++; if (busy_cyc[0] - s_bz != 161) begin bad++; $display("FAIL t1_busy_len: got %0d want 161", busy_cyc[0] - s_bz); end
    total++; if (done_cnt[0] - s_dn != 1) begin bad++; $display("FAIL t1_done_cnt: got %0d want 1", done_cnt[0] - s_dn); end
    total++; if (starts[0] - s_st != 1 || stops[0] - s_sp != 1) begin
      bad++; $display("FAIL t1_start_stop: got %0d/%0d want 1/1", starts[0] - s_st, stops[0] - s_sp); end
    total++; if (nack_v[0] !== 1'b0) begin bad++; $display("FAIL t1_nack: got %b want 0", nack_v[0]); end
  endtask

  task automatic test_stream_stall();
    int s_fr = nfr[0], s_sp = stops[0], s_dn = done_cnt[0], ll;
    plan[0] = '0; addr_v[0] = 7'h50; start_v[0] = 1'b1;
    @(negedge clk); start_v[0] = 1'b0;
    feed(0, 8'h01, 1'b0, 0, ll);
    feed(0, 8'h02, 1'b0, 20, ll);
    total++; if (ll != 20) begin bad++; $display("FAIL t2_load_hold: got %0d want 20", ll); end
    feed(0, 8'h03, 1'b1, 0, ll);
    wait_done(0, "t2_done");
    @(negedge clk);
    total++; if (nfr[0] - s_fr != 4) begin bad++; $display("FAIL t2_frames: got %0d want 4", nfr[0] - s_fr); end
    total++; if ({frames[0][s_fr+1], frames[0][s_fr+2], frames[0][s_fr+3]} !== {9'h002, 9'h004, 9'h006}) begin
      bad++; $display("FAIL t2_bytes: got %h %h %h want 002 004 006",
                      frames[0][s_fr+1], frames[0][s_fr+2], frames[0][s_fr+3]); end
    total++; if (stops[0] - s_sp != 1 || done_cnt[0] - s_dn != 1) begin
      bad++; $display("FAIL t2_stop_done: got %0d/%0d want 1/1", stops[0] - s_sp, done_cnt[0] - s_dn); end
  endtask

  task automatic test_addr_nack();
    int s_fr = nfr[0], s_sp = stops[0], s_rd = ready_cnt[0], ll;
    plan[0] = 16'h0001; addr_v[0] = 7'h50; start_v[0] = 1'b1;
    @(negedge clk); start_v[0] = 1'b0;
    wait_done(0, "t3_done");
    @(negedge clk);
    total++; if (ready_cnt[0] != s_rd) begin bad++; $display("FAIL t3_no_ready: got %0d want 0", ready_cnt[0] - s_rd); end
    total++; if (nfr[0] - s_fr != 1 || frames[0][s_fr] !== 9'h141) begin
      bad++; $display("FAIL t3_addr_frame: got %0d/%h want 1/141", nfr[0] - s_fr, frames[0][s_fr]); end
    total++; if (stops[0] - s_sp != 1) begin bad++; $display("FAIL t3_stop: got %0d want 1", stops[0] - s_sp); end
    repeat (5) @(negedge clk);
    total++; if (nack_v[0] !== 1'b1) begin bad++; $display("FAIL t3_nack_sticky: got %b want 1", nack_v[0]); end
    plan[0] = '0; start_v[0] = 1'b1;
    @(negedge clk); start_v[0] = 1'b0;
    total++; if ({busy_v[0], nack_v[0]} !== 2'b10) begin
      bad++; $display("FAIL t3_nack_clear: busy,nack got %b want 10", {busy_v[0], nack_v[0]}); end
    feed(0, 8'h5A, 1'b1, 0, ll);
    wait_done(0, "t3_done2");
    @(negedge clk);
    total++; if (nack_v[0] !== 1'b0) begin bad++; $display("FAIL t3_nack_after: got %b want 0", nack_v[0]); end
  endtask

  task automatic test_nack_continue();
    int s_fr = nfr[1], s_sp = stops[1], s_dn = done_cnt[1], ll;
    plan[1] = 16'h0002; addr_v[1] = 7'h22; start_v[1] = 1'b1;
    @(negedge clk); start_v[1] = 1'b0;
    feed(1, 8'h11, 1'b0, 0, ll);
    feed(1, 8'h99, 1'b1, 0, ll);
    wait_done(1, "t4_done");
    @(negedge clk);
    total++; if (nfr[1] - s_fr != 3) begin bad++; $display("FAIL t4_frames: got %0d want 3", nfr[1] - s_fr); end
    total++; if ({frames[1][s_fr], frames[1][s_fr+1], frames[1][s_fr+2]} !== {9'h088, 9'h023, 9'h132}) begin
      bad++; $display("FAIL t4_bytes: got %h %h %h want 088 023 132",
                      frames[1][s_fr], frames[1][s_fr+1], frames[1][s_fr+2]); end
    total++; if (nack_v[1] !== 1'b1) begin bad++; $display("FAIL t4_nack: got %b want 1", nack_v[1]); end
    total++; if (stops[1] - s_sp != 1 || done_cnt[1] - s_dn != 1) begin
      bad++; $display("FAIL t4_stop_done: got %0d/%0d want 1/1", stops[1] - s_sp, done_cnt[1] - s_dn); end
  endtask

  task automatic test_async_reset();
    int ll;
    plan[0] = '0; addr_v[0] = 7'h50; start_v[0] = 1'b1;
    @(negedge clk); start_v[0] = 1'b0;
    feed(0, 8'h00, 1'b1, 0, ll);
    repeat (10) @(negedge clk);
    total++; if (busy_v[0] !== 1'b1) begin bad++; $display("FAIL t5_busy_pre: got %b want 1", busy_v[0]); end
    #2 reset = 1'b0;
    #1;
    total++; if ({sda_oe_v[0], scl_oe_v[0], busy_v[0]} !== 3'b000) begin
      bad++; $display("FAIL t5_async_clear: sda,scl,busy got %b want 000", {sda_oe_v[0], scl_oe_v[0], busy_v[0]}); end
    @(negedge clk); reset = 1'b1;
    @(negedge clk);
    data_v[0] = 8'h0F; tx_last_v[0] = 1'b1; tx_valid_v[0] = 1'b1; start_v[0] = 1'b1;
    @(negedge clk); start_v[0] = 1'b0;
    total++; if ({busy_v[0], sda_oe_v[0], scl_oe_v[0]} !== 3'b100) begin
      bad++; $display("FAIL t5_start_q0: busy,sda,scl got %b want 100", {busy_v[0], sda_oe_v[0], scl_oe_v[0]}); end
    repeat (3) @(negedge clk);
    total++; if ({sda_oe_v[0], scl_oe_v[0]} !== 2'b00) begin
      bad++; $display("FAIL t5_start_q1: sda,scl got %b want 00", {sda_oe_v[0], scl_oe_v[0]}); end
    @(negedge clk);
    total++; if ({sda_oe_v[0], scl_oe_v[0]} !== 2'b10) begin
      bad++; $display("FAIL t5_start_q2: sda,scl got %b want 10", {sda_oe_v[0], scl_oe_v[0]}); end
    wait_done(0, "t5_done");
    tx_valid_v[0] = 1'b0; tx_last_v[0] = 1'b0;
    @(negedge clk);
    total++; if ({frames[0][nfr[0]-2], frames[0][nfr[0]-1]} !== {9'h140, 9'h01E}) begin
      bad++; $display("FAIL t5_frames: got %h %h want 140 01e", frames[0][nfr[0]-2], frames[0][nfr[0]-1]); end
  endtask

  task automatic test_start_ignored();
    int s_fr = nfr[0], s_st = starts[0], s_dn = done_cnt[0];
    plan[0] = '0; addr_v[0] = 7'h50; data_v[0] = 8'h3C; tx_last_v[0] = 1'b1; tx_valid_v[0] = 1'b1;
    start_v[0] = 1'b1;
    @(negedge clk); start_v[0] = 1'b0;
    repeat (30) @(negedge clk);
    addr_v[0] = 7'h11; start_v[0] = 1'b1;
    @(negedge clk); start_v[0] = 1'b0;
    wait_done(0, "t6_done");
    start_v[0] = 1'b1;
    @(negedge clk); start_v[0] = 1'b0;
    repeat (20) @(negedge clk);
    tx_valid_v[0] = 1'b0; tx_last_v[0] = 1'b0;
    total++; if (busy_v[0] !== 1'b0) begin bad++; $display("FAIL t6_busy: got %b want 0", busy_v[0]); end
    total++; if (starts[0] - s_st != 1 || done_cnt[0] - s_dn != 1) begin
      bad++; $display("FAIL t6_one_xfer: starts/done got %0d/%0d want 1/1", starts[0] - s_st, done_cnt[0] - s_dn); end
    total++; if (nfr[0] - s_fr != 2 || frames[0][s_fr] !== 9'h140 || frames[0][s_fr+1] !== 9'h078) begin
      bad++; $display("FAIL t6_frames: got %0d %h %h want 2 140 078", nfr[0] - s_fr, frames[0][s_fr], frames[0][s_fr+1]); end
  endtask

  initial begin
    plan[0] = '0; plan[1] = '0;
    addr_v[0] = '0; addr_v[1] = '0; data_v[0] = '0; data_v[1] = '0;
    #1 reset = 1'b0;
    repeat (3) @(negedge clk);
    test_reset();
    test_single_byte();
    test_stream_stall();
    test_addr_nack();
    test_nack_continue();
    test_async_reset();
    test_start_ignored();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
